// File: rtl/pn_pkg.sv
// Shared constants and the single-step LFSR function for the PN source family.
package pn_pkg;

  localparam logic [4:0]  TAPS_5       = 5'b01001;
  localparam logic [6:0]  TAPS_7       = 7'b0000011;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_000D;

  // Maximal-length tap masks; bit k set means state[k] joins the feedback XOR.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      3:       return 32'h0000_0005;
      4:       return 32'h0000_0009;
      5:       return 32'(TAPS_5);
      6:       return 32'h0000_0021;
      7:       return 32'(TAPS_7);
      8:       return 32'h0000_0071;
      9:       return 32'h0000_0021;
      10:      return 32'h0000_0081;
      11:      return 32'h0000_0201;
      12:      return 32'h0000_0053;
      13:      return 32'h0000_001B;
      14:      return 32'h0000_002B;
      15:      return 32'h0000_4001;
      16:      return 32'h0000_A011;
      17:      return 32'h0000_4001;
      18:      return 32'h0000_0801;
      19:      return 32'h0000_0047;
      20:      return 32'h0002_0001;
      21:      return 32'h0008_0001;
      22:      return 32'h0020_0001;
      23:      return 32'h0004_0001;
      24:      return 32'h00C2_0001;
      25:      return 32'h0040_0001;
      26:      return 32'h0000_0047;
      27:      return 32'h0000_0027;
      28:      return 32'h0200_0001;
      29:      return 32'h0800_0001;
      30:      return 32'h0000_0053;
      31:      return 32'h1000_0001;
      32:      return 32'h0040_0007;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // One Fibonacci step on the low 'width' bits; the feedback enters at the top.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    logic [31:0] next;
    next = state >> 1;
    next[5'(width - 1)] = ^(state & taps);
    return next;
  endfunction

endpackage

// File: rtl/pn_lfsr_advance.sv
// Combinational unroll of OUT_BITS LFSR steps; bits[i] is the bit emitted by step i.
module pn_lfsr_advance
  import pn_pkg::*;
#(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter int               OUT_BITS = 1
) (
  input  logic [WIDTH-1:0]    state,
  output logic [WIDTH-1:0]    next_state,
  output logic [OUT_BITS-1:0] bits
);

  logic [WIDTH-1:0] chain [0:OUT_BITS];

  assign chain[0] = state;

  for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_step
    assign bits[gi]      = chain[gi][0];
    assign chain[gi + 1] = WIDTH'(lfsr_step(32'(chain[gi]), 32'(TAPS), WIDTH));
  end

  assign next_state = chain[OUT_BITS];

endmodule

// File: rtl/pn_gen_param.sv
// Parametrised Fibonacci-LFSR PN source with a valid/ready beat stream and runtime seed load.
// Optional error injection on the output beats is enabled by defining PN_ERR_INJECT_EN.
module pn_gen_param
  import pn_pkg::*;
#(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEFAULT_SEED),
  parameter int               OUT_BITS = 1,
  parameter int               CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    seed_in,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic                seed_err
`ifdef PN_ERR_INJECT_EN
  ,
  input  logic                inj_en,
  input  logic [OUT_BITS-1:0] inj_mask,
  output logic                out_inj
`endif
);

  logic [WIDTH-1:0]    state;
  logic [WIDTH-1:0]    adv_state;
  logic [OUT_BITS-1:0] adv_bits;
  logic [OUT_BITS-1:0] flip;
  logic                sof_pend;
  logic                fill;
  logic                accept;

  pn_lfsr_advance #(
    .WIDTH    (WIDTH),
    .TAPS     (TAPS),
    .OUT_BITS (OUT_BITS)
  ) u_advance (
    .state      (state),
    .next_state (adv_state),
    .bits       (adv_bits)
  );

  assign fill   = en && (!out_valid || out_ready);
  assign accept = out_valid && out_ready;

`ifdef PN_ERR_INJECT_EN
  assign flip = inj_en ? inj_mask : '0;
`else
  assign flip = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEED;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      beat_cnt  <= '0;
      seed_err  <= 1'b0;
      sof_pend  <= 1'b1;
    end else if (load) begin
      // A zero seed would lock the register, so fall back to SEED and flag it.
      if (seed_in == '0) begin
        state    <= SEED;
        seed_err <= 1'b1;
      end else begin
        state <= seed_in;
      end
      out_valid <= 1'b0;
      beat_cnt  <= '0;
      sof_pend  <= 1'b1;
    end else begin
      if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (fill) begin
        state     <= adv_state;
        out_data  <= adv_bits ^ flip;
        out_valid <= 1'b1;
        out_sof   <= sof_pend;
        sof_pend  <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PN_ERR_INJECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_inj <= 1'b0;
    end else if (!load && fill) begin
      out_inj <= inj_en;
    end
  end
`endif

endmodule

// File: tb/tb_pn_gen_param.sv
// Self-checking bench for pn_gen_param: 1-bit and 4-bit beat instances against a bit-sequence model.
module tb_pn_gen_param;

  localparam logic [4:0] P_SEED = 5'b01101;
  localparam logic [4:0] P_TAPS = 5'b01001;
  localparam int         NBITS  = 8192;

  typedef struct {
    logic [3:0] data;
    logic       sof;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // OUT_BITS=1 instance
  logic        en1 = 1'b0, load1 = 1'b0, rdy1 = 1'b1;
  logic [4:0]  seed1 = 5'd0;
  logic [0:0]  data1;
  logic        valid1, sof1, err1;
  logic [15:0] cnt1;

  // OUT_BITS=4 instance with a 3-bit counter so wrap is reachable
  logic       en = 1'b0, load = 1'b0, out_ready = 1'b0;
  logic [4:0] seed_in = 5'd0;
  logic [3:0] out_data;
  logic       out_valid, out_sof, seed_err;
  logic [2:0] beat_cnt;

`ifdef PN_ERR_INJECT_EN
  logic       inj_en = 1'b0, inj1_en = 1'b0, out_inj, out_inj1;
  logic [3:0] inj_mask = 4'd0;
  logic [0:0] inj1_mask = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Model: the PN bit sequence plus the position of the oldest unaccepted beat
  bit         pn [0:NBITS-1];
  int         ptr;
  bit         m_valid;
  int         m_cnt;
  bit         m_err;
  logic [3:0] m_mask;
  bit         m_inj;

  always #5 clk = ~clk;

  pn_gen_param #(.WIDTH(5), .TAPS(P_TAPS), .SEED(P_SEED), .OUT_BITS(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .en(en1), .load(load1), .seed_in(seed1),
    .out_data(data1), .out_valid(valid1), .out_ready(rdy1), .out_sof(sof1),
    .beat_cnt(cnt1), .seed_err(err1)
`ifdef PN_ERR_INJECT_EN
    , .inj_en(inj1_en), .inj_mask(inj1_mask), .out_inj(out_inj1)
`endif
  );

  pn_gen_param #(.WIDTH(5), .TAPS(P_TAPS), .SEED(P_SEED), .OUT_BITS(4), .CNT_W(3)) u4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .beat_cnt(beat_cnt), .seed_err(seed_err)
`ifdef PN_ERR_INJECT_EN
    , .inj_en(inj_en), .inj_mask(inj_mask), .out_inj(out_inj)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Sequence bit n+5 is the XOR of the tapped earlier bits n+k.
  task automatic gen(input logic [4:0] sd);
    for (int n = 0; n < NBITS; n++) begin
      if (n < 5) begin
        pn[n] = sd[n];
      end else begin
        pn[n] = 1'b0;
        for (int k = 0; k < 5; k++)
          if (P_TAPS[k]) pn[n] = pn[n] ^ pn[n - 5 + k];
      end
    end
  endtask

  function automatic logic [3:0] exp_beat(input int p);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = pn[p + i];
    return b;
  endfunction

  task automatic model_reset();
    gen(P_SEED);
    ptr = 0; m_valid = 1'b0; m_cnt = 0; m_err = 1'b0; m_mask = 4'd0; m_inj = 1'b0;
  endtask

  // One clock on u4: apply inputs at the falling edge, check, advance the model.
  task automatic step(input bit e, input bit r, input bit ld, input logic [4:0] sd);
    bit acc, fl;
    en = e; out_ready = r; load = ld; seed_in = sd;
    #1;
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    chk("seed_err", 32'(seed_err), 32'(m_err));
    if (m_valid) begin
      chk("data", 32'(out_data), 32'(exp_beat(ptr) ^ m_mask));
      chk("sof", 32'(out_sof), 32'(ptr == 0));
`ifdef PN_ERR_INJECT_EN
      chk("inj", 32'(out_inj), 32'(m_inj));
`endif
    end
    acc = m_valid && r && !ld;
    fl  = e && (!m_valid || r) && !ld;
    if (ld) begin
      gen((sd == 5'd0) ? P_SEED : sd);
      if (sd == 5'd0) m_err = 1'b1;
      ptr = 0; m_cnt = 0; m_valid = 1'b0;
    end else begin
      if (acc) begin
        ptr   = ptr + 4;
        m_cnt = (m_cnt + 1) % 8;
      end
      if (fl) begin
        m_valid = 1'b1;
`ifdef PN_ERR_INJECT_EN
        m_mask = inj_en ? inj_mask : 4'd0;
        m_inj  = inj_en;
`else
        m_mask = 4'd0;
`endif
      end else if (acc) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    beat_t      tbl4 [0:3];
    logic [7:0] tbl1;
    tbl4[0] = '{4'b1101, 1'b1};
    tbl4[1] = '{4'b1000, 1'b0};
    tbl4[2] = '{4'b1111, 1'b0};
    tbl4[3] = '{4'b1100, 1'b0};
    tbl1    = 8'b1000_1101;  // bit i is the i-th emitted bit: 1,0,1,1,0,0,0,1

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_sof", 32'(out_sof), 0);
    chk("rst_cnt", 32'(beat_cnt), 0);
    chk("rst_err", 32'(seed_err), 0);
    rst = 1'b0;

    // 1-bit beats: two full periods against the model, first eight against the table
    en1 = 1'b1;
    #1 chk("lat1_valid", 32'(valid1), 0);
    for (int k = 0; k < 62; k++) begin
      @(negedge clk);
      chk("b1_valid", 32'(valid1), 1);
      chk("b1_data", 32'(data1), 32'(pn[k]));
      chk("b1_cnt", 32'(cnt1), 32'(k));
      if (k < 8) chk("b1_table", 32'(data1), 32'(tbl1[k]));
      if (k == 0) chk("b1_sof", 32'(sof1), 1);
    end
    en1 = 1'b0;

    // 4-bit beats from reset, full throughput
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 5'd0);
      chk("b4_valid", 32'(out_valid), 1);
      chk("b4_data", 32'(out_data), 32'(tbl4[i].data));
      chk("b4_sof", 32'(out_sof), 32'(tbl4[i].sof));
    end

    // Consumer stall mid-stream, then resume
    repeat (5) step(1, 0, 0, 5'd0);
    repeat (3) step(1, 1, 0, 5'd0);

    // Load during a stalled beat drops it
    step(1, 0, 0, 5'd0);
    step(1, 0, 1, 5'b01101);
    chk("ld_valid", 32'(out_valid), 0);
    chk("ld_cnt", 32'(beat_cnt), 0);
    step(1, 1, 0, 5'd0);
    chk("ld_data", 32'(out_data), 32'(tbl4[0].data));
    chk("ld_sof", 32'(out_sof), 1);

    // Zero seed is rejected and the sequence restarts from SEED
    step(0, 0, 1, 5'd0);
    chk("zs_err", 32'(seed_err), 1);
    repeat (3) step(1, 1, 0, 5'd0);
    chk("zs_sticky", 32'(seed_err), 1);
    chk("zs_data", 32'(out_data), 32'(tbl4[2].data));

`ifdef PN_ERR_INJECT_EN
    step(0, 0, 1, P_SEED);
    step(1, 1, 0, 5'd0);
    inj_en = 1'b1; inj_mask = 4'b0010;
    step(1, 1, 0, 5'd0);
    inj_en = 1'b0; inj_mask = 4'd0;
    chk("inj_data", 32'(out_data), 32'(4'b1010));
    chk("inj_flag", 32'(out_inj), 1);
    step(1, 1, 0, 5'd0);
    chk("inj_next", 32'(out_data), 32'(tbl4[2].data));
    chk("inj_clear", 32'(out_inj), 0);
`endif

    // Counter wrap: 12 full-throughput cycles give 11 accepts, 11 mod 8 = 3
    step(0, 0, 1, 5'b10011);
    repeat (12) step(1, 1, 0, 5'd0);
    chk("wrap_cnt", 32'(beat_cnt), 3);

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    chk("mrst_cnt", 32'(beat_cnt), 0);
    chk("mrst_err", 32'(seed_err), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 1, 0, 5'd0);
    chk("mrst_first", 32'(out_data), 32'(tbl4[0].data));

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      bit         e, r, ld;
      logic [4:0] sd;
      e  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      ld = ($urandom_range(0, 59) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step(e, r, ld, sd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
